// File: rtl/modulo_counter_pkg.sv
// Shared constants for modulo counters and the clock-digit tops built from them.
// The package is named counter_pkg because every counter-based block imports it.
package counter_pkg;

  localparam logic c_DIR_UP   = 1'b1;
  localparam logic c_DIR_DOWN = 1'b0;

  localparam int c_MOD_SEC_UNITS = 10;
  localparam int c_MOD_SEC_TENS  = 6;
  localparam int c_MOD_HOUR_BCD  = 24;

endpackage

// File: rtl/modulo_counter_if.sv
// Signal bundle for one modulo_counter digit.
// master drives the controls and observes the count; slave is the counter side.
interface modulo_counter_if #(
  parameter int c_WIDTH = 4
);

  // Controls are level/strobe signals sampled on every rising clock edge with no
  // handshake. data, wrap and load_error are registered; carry and borrow are
  // combinational from data and the current controls.
  logic               enable;
  logic               up_down;
  logic               load;
  logic [c_WIDTH-1:0] load_data;
  logic [c_WIDTH-1:0] data;
  logic               carry;
  logic               borrow;
  logic               wrap;
  logic               load_error;

  modport master (
    output enable, up_down, load, load_data,
    input  data, carry, borrow, wrap, load_error
  );

  modport slave (
    input  enable, up_down, load, load_data,
    output data, carry, borrow, wrap, load_error
  );

endinterface

// File: rtl/modulo_counter.sv
// Up/down counter over 0..c_MODULO-1 with synchronous load, cascade carry/borrow
// and registered wrap / out-of-range-load pulses.
module modulo_counter
  import counter_pkg::*;
#(
  parameter int c_WIDTH       = 4,
  parameter int c_MODULO      = 10,
  parameter int c_RESET_VALUE = 0
) (
  input  logic               i_Clock,
  input  logic               i_Reset_n,
  input  logic               i_Enable_Count,
  input  logic               i_Up_Down,
  input  logic               i_Load,
  input  logic [c_WIDTH-1:0] i_Load_Data,
  output logic [c_WIDTH-1:0] o_Data,
  output logic               o_Carry,
  output logic               o_Borrow,
  output logic               o_Wrap,
  output logic               o_Load_Error
);

  if (c_MODULO < 2 || c_MODULO > (1 << c_WIDTH)) begin : g_bad_modulo
    $error("modulo_counter: c_MODULO=%0d outside 2..2**c_WIDTH", c_MODULO);
  end
  if (c_RESET_VALUE < 0 || c_RESET_VALUE >= c_MODULO) begin : g_bad_reset
    $error("modulo_counter: c_RESET_VALUE=%0d not below c_MODULO", c_RESET_VALUE);
  end

  // One extra bit so c_MODULO == 2**c_WIDTH is representable and down-count
  // underflow shows up as the top bit.
  localparam logic [c_WIDTH:0]   c_MOD_EXT = (c_WIDTH + 1)'(c_MODULO);
  localparam logic [c_WIDTH-1:0] c_TOP     = c_WIDTH'(c_MODULO - 1);
  localparam logic [c_WIDTH-1:0] c_RST     = c_WIDTH'(c_RESET_VALUE);

  logic [c_WIDTH-1:0] r_data;
  logic               r_wrap;
  logic               r_load_error;
  logic [c_WIDTH-1:0] w_next;
  logic               w_wrap;
  logic               w_load_error;
  logic [c_WIDTH:0]   w_inc;
  logic [c_WIDTH:0]   w_dec;
  logic               w_count_up;

  assign w_inc      = {1'b0, r_data} + (c_WIDTH + 1)'(1);
  assign w_dec      = {1'b0, r_data} - (c_WIDTH + 1)'(1);
  assign w_count_up = (i_Up_Down == c_DIR_UP);

  always_comb begin
    w_next       = r_data;
    w_wrap       = 1'b0;
    w_load_error = 1'b0;
    if (i_Load) begin
      if ({1'b0, i_Load_Data} >= c_MOD_EXT) begin
        w_next       = c_TOP;
        w_load_error = 1'b1;
      end else begin
        w_next = i_Load_Data;
      end
    end else if (i_Enable_Count) begin
      if (w_count_up) begin
        if (w_inc == c_MOD_EXT) begin
          w_next = '0;
          w_wrap = 1'b1;
        end else begin
          w_next = w_inc[c_WIDTH-1:0];
        end
      end else begin
        if (w_dec[c_WIDTH]) begin
          w_next = c_TOP;
          w_wrap = 1'b1;
        end else begin
          w_next = w_dec[c_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_data       <= c_RST;
      r_wrap       <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_data       <= w_next;
      r_wrap       <= w_wrap;
      r_load_error <= w_load_error;
    end
  end

  // Terminal counts are unregistered so the next digit counts on the same edge.
  assign o_Carry      = i_Enable_Count & w_count_up & (r_data == c_TOP) & ~i_Load;
  assign o_Borrow     = i_Enable_Count & ~w_count_up & (r_data == '0) & ~i_Load;
  assign o_Data       = r_data;
  assign o_Wrap       = r_wrap;
  assign o_Load_Error = r_load_error;

endmodule

// File: tb/tb_modulo_counter.sv
// Bench for modulo_counter: mod-10 digit against a queue-fed reference model,
// plus a units/tens cascade and a full-range mod-16 instance.
module tb_modulo_counter;
  import counter_pkg::*;

  localparam int M = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  modulo_counter_if #(.c_WIDTH(4)) u_if ();

  modulo_counter #(.c_WIDTH(4), .c_MODULO(M), .c_RESET_VALUE(0)) u_dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_Enable_Count (u_if.enable),
    .i_Up_Down      (u_if.up_down),
    .i_Load         (u_if.load),
    .i_Load_Data    (u_if.load_data),
    .o_Data         (u_if.data),
    .o_Carry        (u_if.carry),
    .o_Borrow       (u_if.borrow),
    .o_Wrap         (u_if.wrap),
    .o_Load_Error   (u_if.load_error)
  );

  // Cascade: seconds units feeding seconds tens.
  logic       casc_rst_n, casc_en;
  logic [3:0] units_data, tens_data;
  logic       units_carry, units_borrow, units_wrap, units_err;
  logic       tens_carry, tens_borrow, tens_wrap, tens_err;

  modulo_counter #(.c_WIDTH(4), .c_MODULO(c_MOD_SEC_UNITS)) u_units (
    .i_Clock(clk), .i_Reset_n(casc_rst_n), .i_Enable_Count(casc_en),
    .i_Up_Down(c_DIR_UP), .i_Load(1'b0), .i_Load_Data(4'd0),
    .o_Data(units_data), .o_Carry(units_carry), .o_Borrow(units_borrow),
    .o_Wrap(units_wrap), .o_Load_Error(units_err)
  );

  modulo_counter #(.c_WIDTH(4), .c_MODULO(c_MOD_SEC_TENS)) u_tens (
    .i_Clock(clk), .i_Reset_n(casc_rst_n), .i_Enable_Count(units_carry),
    .i_Up_Down(c_DIR_UP), .i_Load(1'b0), .i_Load_Data(4'd0),
    .o_Data(tens_data), .o_Carry(tens_carry), .o_Borrow(tens_borrow),
    .o_Wrap(tens_wrap), .o_Load_Error(tens_err)
  );

  // Full binary range instance.
  logic       m16_rst_n, m16_en, m16_ud, m16_ld;
  logic [3:0] m16_ldd, m16_data;
  logic       m16_carry, m16_borrow, m16_wrap, m16_err;

  modulo_counter #(.c_WIDTH(4), .c_MODULO(16)) u_m16 (
    .i_Clock(clk), .i_Reset_n(m16_rst_n), .i_Enable_Count(m16_en),
    .i_Up_Down(m16_ud), .i_Load(m16_ld), .i_Load_Data(m16_ldd),
    .o_Data(m16_data), .o_Carry(m16_carry), .o_Borrow(m16_borrow),
    .o_Wrap(m16_wrap), .o_Load_Error(m16_err)
  );

  // Scoreboard: {data, carry, borrow, wrap, load_error}
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: values the DUT outputs show during the current cycle.
  int   m_data = 0;
  logic m_wrap = 1'b0;
  logic m_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of mod-10 stimulus; inputs change 1 time unit after the edge.
  task automatic cycle(input logic rst, input logic en, input logic ud,
                       input logic ld, input logic [3:0] ldd);
    logic c, b;
    @(posedge clk);
    #1;
    rst_n          = rst;
    u_if.enable    = en;
    u_if.up_down   = ud;
    u_if.load      = ld;
    u_if.load_data = ldd;
    if (!rst) begin
      m_data = 0;
      m_wrap = 1'b0;
      m_err  = 1'b0;
    end
    c = en && ud && (m_data == M - 1) && !ld;
    b = en && !ud && (m_data == 0) && !ld;
    exp_q.push_back({4'(m_data), c, b, m_wrap, m_err});
    if (!rst) begin
      m_data = 0;
      m_wrap = 1'b0;
      m_err  = 1'b0;
    end else if (ld) begin
      m_err  = (int'(ldd) >= M);
      m_data = m_err ? M - 1 : int'(ldd);
      m_wrap = 1'b0;
    end else if (en) begin
      m_err = 1'b0;
      if (ud) begin
        m_wrap = (m_data == M - 1);
        m_data = (m_data + 1) % M;
      end else begin
        m_wrap = (m_data == 0);
        m_data = (m_data + M - 1) % M;
      end
    end else begin
      m_wrap = 1'b0;
      m_err  = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {u_if.data, u_if.carry, u_if.borrow, u_if.wrap, u_if.load_error};
      check("mod10 {data,carry,borrow,wrap,lderr}", 32'(a), 32'(e));
    end
  end

  initial begin
    int wrap_cnt, carry_cnt;
    rst_n = 1'b0;
    u_if.enable = 1'b0; u_if.up_down = 1'b0; u_if.load = 1'b0; u_if.load_data = '0;
    casc_rst_n = 1'b0; casc_en = 1'b0;
    m16_rst_n = 1'b0; m16_en = 1'b0; m16_ud = 1'b0; m16_ld = 1'b0; m16_ldd = '0;

    // Reset state, then count up through the wrap.
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (10) cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    // Load 7, count down 8 edges through 0 to 9.
    cycle(1, 0, 0, 1, 4'd7);
    repeat (8) cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // Out-of-range load, then load racing a wrap-worthy count.
    cycle(1, 0, 1, 1, 4'd12);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 4'd3);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 4'd0);
    cycle(1, 0, 0, 0, 0);
    // Asynchronous reset at 5, release, resume from 0.
    cycle(1, 0, 1, 1, 4'd5);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    // Random traffic with direction changes, loads and occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)));
    end
    cycle(1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    // Cascade over 60 edges.
    @(posedge clk);
    #1;
    casc_rst_n = 1'b1;
    casc_en    = 1'b1;
    wrap_cnt   = 0;
    carry_cnt  = 0;
    repeat (60) begin
      @(negedge clk);
      if (units_carry) carry_cnt++;
      @(posedge clk);
      #1;
      if (tens_wrap) wrap_cnt++;
    end
    casc_en = 1'b0;
    check("cascade units", 32'(units_data), 32'd0);
    check("cascade tens", 32'(tens_data), 32'd0);
    check("cascade tens wrap pulses", 32'(wrap_cnt), 32'd1);
    check("cascade units carries", 32'(carry_cnt), 32'd6);

    // Mod-16: down from 0 then an in-range load of 15.
    @(negedge clk);
    check("m16 reset data", 32'(m16_data), 32'd0);
    @(posedge clk);
    #1;
    m16_rst_n = 1'b1;
    m16_en    = 1'b1;
    m16_ud    = c_DIR_DOWN;
    @(negedge clk);
    check("m16 borrow at 0", 32'(m16_borrow), 32'd1);
    @(posedge clk);
    #1;
    m16_en = 1'b0;
    @(negedge clk);
    check("m16 data after borrow", 32'(m16_data), 32'd15);
    check("m16 wrap after borrow", 32'(m16_wrap), 32'd1);
    check("m16 borrow idle", 32'(m16_borrow), 32'd0);
    @(posedge clk);
    #1;
    m16_ld  = 1'b1;
    m16_ldd = 4'd15;
    @(posedge clk);
    #1;
    m16_ld = 1'b0;
    @(negedge clk);
    check("m16 load 15 data", 32'(m16_data), 32'd15);
    check("m16 load 15 no error", 32'(m16_err), 32'd0);
    check("m16 load no wrap", 32'(m16_wrap), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
